// File: rtl/maple_pkg.sv
// Shared types for the Maple Bus transaction sequencer.
//   maple_seq_state_t : sequencer FSM states
//   maple_status_t    : result code reported to the register block
//   max_int           : elaboration-time helper for sizing counters
package maple_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX       = 3'd1,
    S_TX_DRAIN = 3'd2,
    S_TURN     = 3'd3,
    S_RX_WAIT  = 3'd4,
    S_RX       = 3'd5,
    S_FIN      = 3'd6
  } maple_seq_state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ABORT   = 2'd2,
    ST_EMPTY   = 2'd3
  } maple_status_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maple_down_counter.sv
// Loadable down-counter that saturates at zero.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : load load_value (has priority over dec)
//   dec          : decrement by one, holds at zero
//   load_value   : value to load
//   zero         : count is zero
module maple_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/maple_txn_sequencer.sv
// Sequences one Maple Bus host transaction: TX, bus turnaround, then reply
// reception with a timeout. Reports a status code and a one-cycle done pulse.
// Ports:
//   aclk, areset            : clock, asynchronous active-high reset
//   start, expect_reply     : begin transaction (IDLE only), reply wanted
//   abort                   : level, forces ABORT from any active state
//   tx_data_count           : TX FIFO occupancy
//   tx_last_hs, transmitting: transmitter TLAST accepted, transmitter active
//   receiving, rx_last_hs   : receiver mid-packet, RX FIFO TLAST accepted
//   enable_tx, enable_rx    : transmitter / receiver enables
//   busy, done, status      : not idle, completion pulse, result code
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// TX        | transmitter enabled, waiting for TLAST handshake
// TX_DRAIN  | transmitter enabled, waiting for it to go quiet
// TURN      | both enables low for TURN_CYCLES cycles
// RX_WAIT   | receiver enabled, waiting for reply start (timed)
// RX        | receiver enabled, waiting for reply TLAST
// FIN       | done pulse, status valid
module maple_txn_sequencer
  import maple_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TURN_CYCLES    = 50,
  parameter int COUNT_W        = 11
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic               expect_reply,
  input  logic               abort,
  input  logic [COUNT_W-1:0] tx_data_count,
  input  logic               tx_last_hs,
  input  logic               transmitting,
  input  logic               receiving,
  input  logic               rx_last_hs,
  output logic               enable_tx,
  output logic               enable_rx,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status
);

  localparam int CW = $clog2(max_int(TIMEOUT_CYCLES, TURN_CYCLES) + 1);

  // TURN exits when the counter reads zero, so it is loaded one short to
  // make TURN last exactly TURN_CYCLES cycles.
  localparam logic [CW-1:0] TURN_LOAD    = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES);

  maple_seq_state_t state_q, state_d;
  maple_status_t    status_q, status_d;
  logic             reply_q, reply_d;

  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] cnt_load_value;
  logic          cnt_zero;

  maple_down_counter #(.W(CW)) u_counter (
    .clk        (aclk),
    .rst        (areset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (cnt_load_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      reply_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      reply_q  <= reply_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    reply_d        = reply_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          reply_d = expect_reply;
          if (tx_data_count == '0) begin
            state_d  = S_FIN;
            status_d = ST_EMPTY;
          end else begin
            state_d = S_TX;
          end
        end
      end

      S_TX: begin
        if (abort) begin
          state_d  = S_FIN;
          status_d = ST_ABORT;
        end else if (tx_last_hs) begin
          state_d = S_TX_DRAIN;
        end
      end

      S_TX_DRAIN: begin
        if (abort) begin
          state_d  = S_FIN;
          status_d = ST_ABORT;
        end else if (!transmitting) begin
          if (!reply_q) begin
            state_d  = S_FIN;
            status_d = ST_OK;
          end else if (TURN_CYCLES == 0) begin
            state_d        = S_RX_WAIT;
            cnt_load       = 1'b1;
            cnt_load_value = TIMEOUT_LOAD;
          end else begin
            state_d        = S_TURN;
            cnt_load       = 1'b1;
            cnt_load_value = TURN_LOAD;
          end
        end
      end

      S_TURN: begin
        if (abort) begin
          state_d  = S_FIN;
          status_d = ST_ABORT;
        end else if (cnt_zero) begin
          state_d        = S_RX_WAIT;
          cnt_load       = 1'b1;
          cnt_load_value = TIMEOUT_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      S_RX_WAIT: begin
        // receiving wins over expiry in the same cycle
        if (abort) begin
          state_d  = S_FIN;
          status_d = ST_ABORT;
        end else if (receiving) begin
          state_d = S_RX;
        end else if (cnt_zero) begin
          state_d  = S_FIN;
          status_d = ST_TIMEOUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      S_RX: begin
        if (abort) begin
          state_d  = S_FIN;
          status_d = ST_ABORT;
        end else if (rx_last_hs) begin
          state_d  = S_FIN;
          status_d = ST_OK;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign enable_tx = (state_q == S_TX) || (state_q == S_TX_DRAIN);
  assign enable_rx = (state_q == S_RX_WAIT) || (state_q == S_RX);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign status    = status_q;

endmodule

// File: tb/tb_maple_txn_sequencer.sv
module tb_maple_txn_sequencer;

  localparam int TIMEOUT = 20;
  localparam int TURN    = 4;
  localparam int CW      = 11;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic          expect_reply;
  logic          abort;
  logic [CW-1:0] tx_data_count;
  logic          tx_last_hs;
  logic          transmitting;
  logic          receiving;
  logic          rx_last_hs;
  logic          enable_tx;
  logic          enable_rx;
  logic          busy;
  logic          done;
  logic [1:0]    status;

  int n_tests = 0;
  int n_fail  = 0;

  maple_txn_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .TURN_CYCLES    (TURN),
    .COUNT_W        (CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .expect_reply  (expect_reply),
    .abort         (abort),
    .tx_data_count (tx_data_count),
    .tx_last_hs    (tx_last_hs),
    .transmitting  (transmitting),
    .receiving     (receiving),
    .rx_last_hs    (rx_last_hs),
    .enable_tx     (enable_tx),
    .enable_rx     (enable_rx),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // enables must never overlap
  always @(negedge aclk) begin
    if (!areset) check("overlap", 32'(enable_tx & enable_rx), 32'd0);
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic check_fin(input string tag, input int st);
    check({tag, "_done"},   32'(done),      32'd1);
    check({tag, "_status"}, 32'(status),    32'(st));
    check({tag, "_en_tx"},  32'(enable_tx), 32'd0);
    check({tag, "_en_rx"},  32'(enable_rx), 32'd0);
    tick;
    check({tag, "_idle_done"}, 32'(done),   32'd0);
    check({tag, "_idle_busy"}, 32'(busy),   32'd0);
    check({tag, "_held"},      32'(status), 32'(st));
  endtask

  // start, TX for 5 cycles, TLAST, drain 3 cycles, then transmitting falls.
  // Returns in the last TX_DRAIN cycle.
  task automatic run_tx(input logic reply);
    tx_data_count = 11'd5;
    expect_reply  = reply;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_en_tx", 32'(enable_tx), 32'd1);
    check("start_busy",  32'(busy),      32'd1);
    transmitting = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    tx_last_hs = 1'b1;
    tick;
    tx_last_hs = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    check("drain_en_tx", 32'(enable_tx), 32'd1);
    transmitting = 1'b0;
  endtask

  // Through TURN into RX_WAIT; returns in the first RX_WAIT cycle.
  task automatic run_turn;
    for (int i = 0; i < TURN; i++) begin
      tick;
      check("turn_en_rx", 32'(enable_rx), 32'd0);
      check("turn_en_tx", 32'(enable_tx), 32'd0);
      check("turn_busy",  32'(busy),      32'd1);
    end
    tick;
    check("rx_wait_en_rx", 32'(enable_rx), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    start = 0; expect_reply = 0; abort = 0; tx_data_count = '0;
    tx_last_hs = 0; transmitting = 0; receiving = 0; rx_last_hs = 0;
    tick; tick;
    check("rst_en_tx",  32'(enable_tx), 32'd0);
    check("rst_en_rx",  32'(enable_rx), 32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_status", 32'(status),    32'd0);
    @(negedge aclk);
    areset = 1'b0;
    tick;

    // normal reply
    run_tx(1'b1);
    run_turn;
    tick; tick;
    receiving = 1'b1;
    tick;
    receiving = 1'b0;
    check("rx_en_rx", 32'(enable_rx), 32'd1);
    tick; tick;
    rx_last_hs = 1'b1;
    tick;
    rx_last_hs = 1'b0;
    check_fin("reply", 0);

    // timeout: done exactly TIMEOUT+1 cycles after enable_rx rises
    run_tx(1'b1);
    run_turn;
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick;
      check("to_wait_done",  32'(done),      32'd0);
      check("to_wait_en_rx", 32'(enable_rx), 32'd1);
    end
    tick;
    check_fin("timeout", 1);

    // empty FIFO, then start during FIN ignored, accepted the cycle after
    tx_data_count = 11'd0;
    expect_reply  = 1'b1;
    start = 1'b1;
    tick;
    check("empty_done",   32'(done),      32'd1);
    check("empty_status", 32'(status),    32'd3);
    check("empty_en_tx",  32'(enable_tx), 32'd0);
    tx_data_count = 11'd5;
    tick;
    check("fin_start_ignored", 32'(busy), 32'd0);
    tick;
    start = 1'b0;
    check("b2b_en_tx", 32'(enable_tx), 32'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_fin("abort_tx", 2);

    // no reply: done one cycle after transmitting falls
    run_tx(1'b0);
    tick;
    check_fin("noreply", 0);

    // abort in TURN, then a fresh transaction completes OK
    run_tx(1'b1);
    tick; tick;
    check("abort_turn_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_fin("abort_turn", 2);
    run_tx(1'b0);
    tick;
    check_fin("after_abort", 0);

    // abort in RX
    run_tx(1'b1);
    run_turn;
    receiving = 1'b1;
    tick;
    check("abort_rx_en_rx", 32'(enable_rx), 32'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    receiving = 1'b0;
    check_fin("abort_rx", 2);

    // asynchronous reset mid-TX (status currently ABORT)
    tx_data_count = 11'd5;
    expect_reply = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    transmitting = 1'b1;
    tick;
    check("pre_rst_en_tx", 32'(enable_tx), 32'd1);
    #2 areset = 1'b1;
    #1;
    check("arst_en_tx",  32'(enable_tx), 32'd0);
    check("arst_busy",   32'(busy),      32'd0);
    check("arst_done",   32'(done),      32'd0);
    check("arst_status", 32'(status),    32'd0);
    #4 areset = 1'b0;
    transmitting = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    run_tx(1'b0);
    tick;
    check_fin("post_rst", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
